// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings for transfer type, response and transfer size.
// Slaves and masters import these so that encodings stay consistent across blocks.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

endpackage

// File: rtl/ahb3lite_imem_responder.sv
// AHB3-Lite read-only instruction store for the fetch port, with programmable wait states and
// two-cycle ERROR responses; a side load port fills the store without ever stalling the bus.
module ahb3lite_imem_responder
    import ahb3lite_pkg::*;
#(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR  = 32'h200,
    parameter int                    WAIT_MAX   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           HSEL,
    input  logic [HADDR_SIZE-1:0]          HADDR,
    input  logic [HDATA_SIZE-1:0]          HWDATA,
    input  logic                           HWRITE,
    input  logic [2:0]                     HSIZE,
    input  logic [2:0]                     HBURST,
    input  logic [3:0]                     HPROT,
    input  logic [1:0]                     HTRANS,
    input  logic                           HREADY,
    output logic                           HREADYOUT,
    output logic                           HRESP,
    output logic [HDATA_SIZE-1:0]          HRDATA,
    input  logic [$clog2(WAIT_MAX+1)-1:0]  wait_cfg,
    input  logic                           load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   load_idx,
    input  logic [HDATA_SIZE-1:0]          load_data,
    output logic [15:0]                    xfer_cnt
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    // One extra bit so the end-of-store limit cannot wrap at the top of the address map.
    localparam logic [HADDR_SIZE:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [HADDR_SIZE:0] LIMIT_EXT = BASE_EXT + (HADDR_SIZE+1)'(4 * MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_hreadyout;
    logic                    w_hresp;

    logic [HDATA_SIZE-1:0]   r_mem [MEM_DEPTH];
    logic [HDATA_SIZE-1:0]   r_hrdata;
    logic [IDX_W-1:0]        r_idx;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [15:0]             r_xfer_cnt;

    logic                    w_accept;
    logic                    w_size_err;
    logic                    w_align_err;
    logic                    w_range_err;
    logic                    w_err;
    logic [HADDR_SIZE-1:0]   w_offset;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_rd_idx;
    logic [WAIT_W-1:0]       w_wait;

    // Address-phase decode; only meaningful on a cycle where w_accept is high.
    assign w_accept    = HSEL & HREADY & HTRANS[1] & w_hreadyout;
    assign w_size_err  = (HSIZE > HSIZE_WORD);
    assign w_align_err = ((HSIZE == HSIZE_HWORD) && HADDR[0]) ||
                         ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign w_range_err = ({1'b0, HADDR} < BASE_EXT) || ({1'b0, HADDR} >= LIMIT_EXT);
    assign w_err       = HWRITE | w_size_err | w_align_err | w_range_err;
    assign w_offset    = HADDR - BASE_ADDR;
    assign w_idx       = w_offset[IDX_W+1:2];
    assign w_wait      = (wait_cfg > WAIT_W'(WAIT_MAX)) ? WAIT_W'(WAIT_MAX) : wait_cfg;
    assign w_rd_idx    = (r_state == S_WAIT) ? r_idx : w_idx;

    logic w_unused;
    assign w_unused = &{1'b0, HWDATA, HBURST, HPROT, HTRANS[0],
                        w_offset[HADDR_SIZE-1:IDX_W+2], w_offset[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RESP, S_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_ERR1;
                    end else if (w_wait == '0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt <= WAIT_W'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = HRESP_OKAY;
        case (r_state)
            S_WAIT: w_hreadyout = 1'b0;
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = HRESP_ERROR;
            end
            S_ERR2: w_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Store write has no reset; a same-edge read sees the pre-load word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_hrdata   <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_accept && !w_err) begin
                r_idx      <= w_idx;
                r_wait_cnt <= w_wait;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            end
            if (w_next == S_RESP) begin
                r_hrdata <= r_mem[w_rd_idx];
            end
            // RESP always lasts exactly one cycle, so every RESP cycle is a completed read.
            if (r_state == S_RESP) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    assign HREADYOUT = w_hreadyout;
    assign HRESP     = w_hresp;
    assign HRDATA    = r_hrdata;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
